// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the SISC fetch unit: default widths, instruction
// field positions, fetch FSM states and the opcode values the unit cares about.
package fetch_unit_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_TIMEOUT = 15;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        OP_NOOP = 4'd0,
        OP_HLT  = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus: the fetch unit is the master, memory the slave.
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// Combinational next-PC selection: pc+1, pc+1+imm (relative) or imm (absolute),
// all modulo 2^ADDR_W through natural wrap of the ADDR_W-bit adders.
module pc_next_calc #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_imm,
    input  logic              i_pc_sel,
    input  logic              i_br_sel,
    output logic [ADDR_W-1:0] o_next_pc
);
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_pc_inc = i_pc + ADDR_W'(1);

    always_comb begin
        // NOTE: default assignment first keeps always_comb free of inferred latches.
        o_next_pc = w_pc_inc;
        if (i_pc_sel) begin
            if (i_br_sel) o_next_pc = i_imm;
            else          o_next_pc = w_pc_inc + i_imm;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// SISC program counter + instruction register with a req/ack instruction fetch FSM.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    fetch_unit_if.master       imem,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [ADDR_W-1:0]  pc,
    output logic               fetch_busy,
    output logic               ir_valid,
    output logic               fetch_err
);
    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_addr;
    logic [INSTR_W-1:0] r_ir;
    logic               r_req;
    logic               r_busy;
    logic               r_valid;
    logic [ADDR_W-1:0]  w_next_pc;
    logic [ADDR_W-1:0]  w_imm;
    logic               w_ack;
    logic               w_tmo;

    // imm is taken sign-agnostic and resized to the PC width.
    assign w_imm = ADDR_W'(r_ir[IMM_HI:IMM_LO]);

    pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
        .i_pc      (r_pc),
        .i_imm     (w_imm),
        .i_pc_sel  (pc_sel),
        .i_br_sel  (br_sel),
        .o_next_pc (w_next_pc)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)        r_pc <= '0;
        else if (pc_rst)   r_pc <= '0;
        else if (pc_write) r_pc <= w_next_pc;
    end

    assign w_ack = (r_state != ST_IDLE) && imem.imem_ack;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    assign w_tmo = (r_state != ST_IDLE) && !imem.imem_ack &&
                   (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) r_tmo_cnt <= '0;
            else                    r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (w_tmo) r_err <= 1'b1;
        end
    end

    assign fetch_err = r_err;
`else
    assign w_tmo     = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_ir    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Address is the pre-update PC even if pc_write fires this cycle.
                    if (ir_load) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                        r_busy  <= 1'b1;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (w_ack || w_tmo) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_ir    <= w_ack ? imem.imem_rdata : '0;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_addr;
    assign ir             = r_ir;
    assign opcode         = r_ir[OPC_HI:OPC_LO];
    assign mm             = r_ir[MM_HI:MM_LO];
    assign pc             = r_pc;
    assign fetch_busy     = r_busy;
    assign ir_valid       = r_valid;
endmodule
